// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with one access in flight on a valid/ready memory port.
// Optional WAIT-state timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int DATAWIDTH = 32
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] EXU_data,
    input  logic [DATAWIDTH-1:0] gpr_rdata2_in,
    input  logic [3:0]           LSU_mode,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [DATAWIDTH-1:0] mem_addr,
    output logic                 mem_wen,
    output logic [DATAWIDTH-1:0] mem_wdata,
    output logic [3:0]           mem_wmask,
    input  logic                 mem_resp_valid,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] LSU_data,
    output logic                 lsu_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [DATAWIDTH-1:0] addr, wd, res, res_nx, rsh, ld;
    logic [3:0] mode, mask;
    logic [4:0] sh;
    logic err, err_nx, bad, req, st;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == REQ)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt + 1'b1;
    end
`endif
    assign bad = (LSU_mode[2:1] == 2'b11) || (LSU_mode[2:1] == 2'b01 && EXU_data[0]) ||
                 (LSU_mode[2:1] == 2'b10 && |EXU_data[1:0]);
    assign sh   = {addr[1:0], 3'b000};
    assign rsh  = mem_rdata >> sh;
    assign ld   = mode[2:1] == 2'b00 ? {{24{~mode[3] & rsh[7]}}, rsh[7:0]} :
                  mode[2:1] == 2'b01 ? {{16{~mode[3] & rsh[15]}}, rsh[15:0]} : rsh;
    assign mask = mode[2:1] == 2'b00 ? 4'b0001 << addr[1:0] :
                  mode[2:1] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign req  = state == REQ;
    assign st   = req && mode[0];
    assign in_ready      = state == IDLE;
    assign out_valid     = state == DONE;
    assign mem_req_valid = req;
    assign mem_addr      = req ? {addr[DATAWIDTH-1:2], 2'b00} : '0;
    assign mem_wen       = st;
    assign mem_wmask     = st ? mask : 4'b0000;
    assign mem_wdata     = req ? wd << sh : '0;
    assign LSU_data      = res;
    assign lsu_err       = err;
    always_comb begin
        state_nx = state;
        res_nx   = res;
        err_nx   = err;
        case (state)
            IDLE: if (in_valid) begin
                state_nx = bad ? DONE : REQ;
                res_nx   = '0;
                err_nx   = bad;
            end
            REQ:  if (mem_req_ready) state_nx = WAIT;
            WAIT: if (mem_resp_valid) begin
                state_nx = DONE;
                res_nx   = mode[0] ? '0 : ld;
                err_nx   = 1'b0;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
                state_nx = DONE;
                res_nx   = '0;
                err_nx   = 1'b1;
            end
`endif
            default: if (out_ready) state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            wd    <= '0;
            mode  <= '0;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            res   <= res_nx;
            err   <= err_nx;
            if (in_valid && in_ready) begin
                addr <= EXU_data;
                wd   <= gpr_rdata2_in;
                mode <= LSU_mode;
            end
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table, backpressure/reset/timeout sequences and
// randomized transactions checked against a byte-level reference model.
module tb_lsu_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 0, in_ready, mem_req_valid, mem_req_ready = 0, mem_wen;
    logic mem_resp_valid = 0, out_valid, out_ready = 0, lsu_err;
    logic [31:0] EXU_data = 0, gpr_rdata2_in = 0, mem_addr, mem_wdata, mem_rdata = 0, LSU_data;
    logic [3:0] LSU_mode = 0, mem_wmask;
    int ncmp = 0, nbad = 0;
    always #5 clk = ~clk;

    lsu_ctrl #(.DATAWIDTH(32)
`ifdef LSU_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .EXU_data(EXU_data), .gpr_rdata2_in(gpr_rdata2_in), .LSU_mode(LSU_mode),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .LSU_data(LSU_data), .lsu_err(lsu_err)
    );

    typedef struct {
        logic [31:0] a, d;
        logic [3:0]  m;
        logic [31:0] rd, ed;
        logic        ee;
        logic [3:0]  ew;
        logic [31:0] ewd;
        int          lat;
    } vec_t;
    vec_t vt[11];

    logic obs_req, obs_wen, obs_err, req_unst, out_unst, rdy_bad, timed_out;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic [3:0] obs_wmask;
    int obs_lat, obs_nreq, obs_nout;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Expected result from the access rules, lane by lane.
    function automatic void model(input logic [31:0] a, d, rd, input logic [3:0] m,
                                  output logic [31:0] ed, output logic ee,
                                  output logic [3:0] ew, output logic [31:0] ewd);
        int n, off;
        n   = (m[2:1] == 0) ? 1 : (m[2:1] == 1) ? 2 : 4;
        off = int'(a % 4);
        ee  = (m[2:1] == 3) || (a % n != 0);
        ew  = 0;
        ed  = 0;
        ewd = d << (8 * off);
        for (int i = 0; i < 4; i++)
            if (m[0] && !ee && i >= off && i < off + n) ew[i] = 1'b1;
        if (!m[0] && !ee) begin
            for (int i = 0; i < n; i++)
                ed |= ((rd >> (8 * (off + i))) & 32'hFF) << (8 * i);
            if (!m[3] && n < 4 && ed[8*n-1]) ed |= 32'hFFFFFFFF << (8 * n);
        end
    endfunction

    task automatic do_txn(logic [31:0] a, d, m4, rd, int rq_dly, rs_dly, o_dly);
        int cyc = 0, rst_c = 0, ost = 0, rwait = 0;
        logic pend = 0, done = 0;
        {obs_req, obs_wen, obs_err, req_unst, out_unst, rdy_bad, timed_out} = '0;
        {obs_addr, obs_wdata, obs_data, obs_wmask} = '0;
        obs_lat = 0; obs_nreq = 0; obs_nout = 0;
        @(negedge clk);
        out_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
        if (!in_ready) rdy_bad = 1;
        in_valid = 1; EXU_data = a; gpr_rdata2_in = d; LSU_mode = m4[3:0];
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = 0; mem_resp_valid = 0; mem_rdata = $urandom;
            if (in_ready) rdy_bad = 1;
            if (pend) begin
                if (rwait == 0) begin mem_resp_valid = 1; mem_rdata = rd; pend = 0; end
                else rwait--;
            end
            mem_req_ready = 0;
            if (mem_req_valid) begin
                if (!obs_req) begin
                    obs_req = 1; obs_addr = mem_addr; obs_wen = mem_wen;
                    obs_wmask = mem_wmask; obs_wdata = mem_wdata;
                end else if ({mem_addr, mem_wen, mem_wmask, mem_wdata} !==
                             {obs_addr, obs_wen, obs_wmask, obs_wdata}) req_unst = 1;
                obs_nreq++;
                if (rst_c == rq_dly) begin mem_req_ready = 1; pend = 1; rwait = rs_dly; end
                else rst_c++;
            end
            if (out_valid) begin
                if (obs_nout == 0) begin obs_lat = cyc; obs_data = LSU_data; obs_err = lsu_err; end
                else if ({LSU_data, lsu_err} !== {obs_data, obs_err}) out_unst = 1;
                obs_nout++;
                if (ost == o_dly) begin out_ready = 1; done = 1; end
                else ost++;
            end
        end
        if (!done) begin
            timed_out = 1;
            rst_n = 0; #1 rst_n = 1;
        end
    endtask

    task automatic verify(string tag, logic [31:0] a, logic [3:0] m, logic [31:0] ed,
                          logic ee, logic [3:0] ew, logic [31:0] ewd, int el);
        chk({tag, " completes"}, 32'(timed_out), 0);
        chk({tag, " req_issued"}, 32'(obs_req), 32'(!ee));
        if (!ee) begin
            chk({tag, " mem_addr"}, obs_addr, {a[31:2], 2'b00});
            chk({tag, " mem_wen"}, 32'(obs_wen), 32'(m[0]));
            chk({tag, " mem_wmask"}, 32'(obs_wmask), 32'(ew));
            if (m[0]) chk({tag, " mem_wdata"}, obs_wdata, ewd);
            chk({tag, " req_stable"}, 32'(req_unst), 0);
        end
        chk({tag, " LSU_data"}, obs_data, ed);
        chk({tag, " lsu_err"}, 32'(obs_err), 32'(ee));
        chk({tag, " out_stable"}, 32'(out_unst), 0);
        chk({tag, " in_ready_busy"}, 32'(rdy_bad), 0);
        if (el > 0) chk({tag, " latency"}, obs_lat, el);
    endtask

    initial begin
        logic [31:0] ed, ewd, a, d, rd;
        logic [3:0] ew, m;
        logic ee, seen;
        int q, s, o;
        vt[0]  = '{32'h80000003, 32'h0,        4'h0, 32'h8A000000, 32'hFFFFFF8A, 0, 4'b0000, 32'h0,        3};
        vt[1]  = '{32'h80000002, 32'h0,        4'hA, 32'hBEEF1234, 32'h0000BEEF, 0, 4'b0000, 32'h0,        3};
        vt[2]  = '{32'h80000002, 32'h0000ABCD, 4'h3, 32'h0,        32'h0,        0, 4'b1100, 32'hABCD0000, 3};
        vt[3]  = '{32'h80000001, 32'h0,        4'h4, 32'h12345678, 32'h0,        1, 4'b0000, 32'h0,        1};
        vt[4]  = '{32'h00000100, 32'h0,        4'h6, 32'h12345678, 32'h0,        1, 4'b0000, 32'h0,        1};
        vt[5]  = '{32'h00000010, 32'hDEADBEEF, 4'h5, 32'h0,        32'h0,        0, 4'b1111, 32'hDEADBEEF, 3};
        vt[6]  = '{32'h00000021, 32'h123456AB, 4'h1, 32'h0,        32'h0,        0, 4'b0010, 32'h3456AB00, 3};
        vt[7]  = '{32'h00000040, 32'h0,        4'h2, 32'h00008001, 32'hFFFF8001, 0, 4'b0000, 32'h0,        3};
        vt[8]  = '{32'h00000042, 32'h0,        4'h8, 32'h00F00000, 32'h000000F0, 0, 4'b0000, 32'h0,        3};
        vt[9]  = '{32'h00000044, 32'h0,        4'h4, 32'hCAFEF00D, 32'hCAFEF00D, 0, 4'b0000, 32'h0,        3};
        vt[10] = '{32'h00000013, 32'h0000FFFF, 4'h3, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1};

        #12;
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst outputs", {mem_req_valid, mem_wen, out_valid, lsu_err, mem_wmask}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst LSU_data", LSU_data, 0);
        @(negedge clk) rst_n = 1;

        foreach (vt[i]) begin
            do_txn(vt[i].a, vt[i].d, 32'(vt[i].m), vt[i].rd, 0, 0, 0);
            verify($sformatf("vec%0d", i), vt[i].a, vt[i].m, vt[i].ed, vt[i].ee, vt[i].ew, vt[i].ewd, vt[i].lat);
        end

        do_txn(32'h00000006, 32'h00005A5A, 32'h3, 32'h0, 5, 0, 4);
        verify("bp_store", 32'h6, 4'h3, 32'h0, 0, 4'b1100, 32'h5A5A0000, 0);
        chk("bp req_cycles", obs_nreq, 6);
        chk("bp out_cycles", obs_nout, 5);

        @(negedge clk);
        out_ready = 0; in_valid = 1; EXU_data = 32'h200; LSU_mode = 4'h4; mem_req_ready = 1;
        @(negedge clk);
        in_valid = 0;
        chk("rstw in_req", 32'(mem_req_valid), 1);
        @(negedge clk);
        mem_req_ready = 0;
        chk("rstw in_wait", {31'(0), in_ready | mem_req_valid | out_valid}, 0);
        #2 rst_n = 0;
        #1;
        chk("rstw in_ready", 32'(in_ready), 1);
        chk("rstw outputs", {mem_req_valid, mem_wen, out_valid, lsu_err, mem_wmask}, 0);
        chk("rstw LSU_data", LSU_data, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk) begin mem_resp_valid = 1; mem_rdata = 32'h11223344; end
        @(negedge clk) mem_resp_valid = 0;
        seen = 0;
        repeat (4) @(negedge clk) if (out_valid || !in_ready) seen = 1;
        chk("rstw late_resp", 32'(seen), 0);

`ifdef LSU_TIMEOUT_EN
        do_txn(32'h00000300, 32'h0, 32'h4, 32'h0, 0, 1000, 0);
        verify("tmo abort", 32'h300, 4'h4, 32'h0, 1, 4'b0, 32'h0, 10);
        do_txn(32'h00000301, 32'h0, 32'h0, 32'h0000C300, 0, 7, 0);
        verify("tmo edge", 32'h301, 4'h0, 32'hFFFFFFC3, 0, 4'b0, 32'h0, 10);
`endif

        for (int i = 0; i < 150; i++) begin
            a = $urandom; d = $urandom; rd = $urandom; m = 4'($urandom);
            if (i % 2 == 0) a[1:0] = 2'b00;
            q = $urandom_range(0, 3); s = $urandom_range(0, 3); o = $urandom_range(0, 3);
            if (i % 4 == 0) begin q = 0; s = 0; o = 0; end
            model(a, d, rd, m, ed, ee, ew, ewd);
            do_txn(a, d, 32'(m), rd, q, s, o);
            verify($sformatf("rnd%0d", i), a, m, ed, ee, ew, ewd,
                   (q == 0 && s == 0 && o == 0) ? (ee ? 1 : 3) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
